// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul result writer: state encoding, default
// geometry and a counter-width helper.
package matmul_pkg;

  localparam int DEF_N  = 8;
  localparam int DEF_DW = 8;
  localparam int ROW_W  = DEF_N * DEF_DW;
  localparam int CNT_W  = $clog2(DEF_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A one-row matrix still needs a 1-bit row counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_sat_shift.sv
// Combinational requantizer: arithmetic right shift by SHIFT, then signed
// saturation of the result into DW bits.
module matmul_sat_shift #(
  parameter int ACC_W = 16,
  parameter int DW    = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [DW-1:0]    o_q
);

  localparam int MAX_I = (1 << (DW - 1)) - 1;
  localparam int MIN_I = -(1 << (DW - 1));
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(MIN_I);

  logic signed [ACC_W-1:0] w_s;

  assign w_s = i_acc >>> SHIFT;

  always_comb begin
    o_q = w_s[DW-1:0];
    if (w_s > MAX_S) begin
      o_q = {1'b0, {(DW-1){1'b1}}};
    end else if (w_s < MIN_S) begin
      o_q = {1'b1, {(DW-1){1'b0}}};
    end
  end

endmodule

// File: rtl/matmul_result_writer.sv
// Captures the requantized NxN accumulator array on a done_mat_mul rise and
// streams it row by row into the result RAM through a valid/ready port.
//
//   state    | meaning
//   ST_IDLE  | waiting for a done_mat_mul rise
//   ST_WRITE | issuing rows 0..N-1, busy
//   ST_DONE  | all rows accepted, done held until clear_done
module matmul_result_writer
  import matmul_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int ACC_W      = 16,
  parameter int DW         = DEF_DW,
  parameter int SHIFT      = 0,
  parameter int ADDR_W     = 7,
  parameter int ROW_STRIDE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic                   i_done_mat_mul,
  input  logic                   i_clear_done,
  input  logic [ADDR_W-1:0]      i_base_addr,
  input  logic [N*N*ACC_W-1:0]   i_c_data,
  input  logic                   i_wr_ready,
  output logic                   o_wr_en,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic [N*DW-1:0]        o_wr_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun
);

  localparam int L_ROW_W = N * DW;
  localparam int L_CNT_W = cnt_w(N);
  localparam logic [L_CNT_W-1:0] LAST_ROW = L_CNT_W'(N - 1);
  localparam logic [ADDR_W-1:0]  STRIDE   = ADDR_W'(ROW_STRIDE);

  state_t                r_state;
  state_t                w_next;
  logic                  r_done_q;
  logic [L_CNT_W-1:0]    r_row;
  logic [ADDR_W-1:0]     r_base;
  logic [N*N*DW-1:0]     r_cap;
  logic                  r_overrun;
  logic [N*N*DW-1:0]     w_q;
  logic                  w_rise;
  logic                  w_capture;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_ovr_set;

  for (genvar gi = 0; gi < N * N; gi++) begin : g_sat
    matmul_sat_shift #(
      .ACC_W (ACC_W),
      .DW    (DW),
      .SHIFT (SHIFT)
    ) u_sat (
      .i_acc (i_c_data[gi*ACC_W +: ACC_W]),
      .o_q   (w_q[gi*DW +: DW])
    );
  end

  assign w_rise = i_done_mat_mul & ~r_done_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_capture = 1'b1;
          w_next    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_ovr_set = w_rise;
        if (i_wr_ready) begin
          w_accept = 1'b1;
          if (r_row == LAST_ROW) begin
            w_last = 1'b1;
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A new rise outranks a coincident clear_done.
        if (w_rise) begin
          w_capture = 1'b1;
          w_next    = ST_WRITE;
        end else if (i_clear_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_done_q  <= 1'b0;
      r_row     <= '0;
      r_base    <= '0;
      r_cap     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_done_q <= i_done_mat_mul;
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
      if (w_capture) begin
        r_row  <= '0;
        r_base <= i_base_addr;
        r_cap  <= w_q;
      end else if (w_accept) begin
        r_row <= w_last ? '0 : r_row + 1'b1;
      end
    end
  end

  // Address arithmetic is modulo 2^ADDR_W; wrap past the top is intended.
  assign o_wr_addr = r_base + ADDR_W'(r_row) * STRIDE;
  assign o_wr_data = r_cap[r_row*L_ROW_W +: L_ROW_W];
  assign o_wr_en   = (r_state == ST_WRITE);
  assign o_busy    = (r_state == ST_WRITE);
  assign o_done    = (r_state == ST_DONE);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_matmul_result_writer.sv
// Directed bench for matmul_result_writer: expected rows are queued at each
// capture and compared against every write the DUT presents.
module tb_matmul_result_writer;
  import matmul_pkg::*;

  localparam int N  = DEF_N;
  localparam int AW = 7;
  localparam int AC = 16;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [ROW_W-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               resetn;
  logic               done_mm;
  logic               clear_done;
  logic [AW-1:0]      base;
  logic [N*N*AC-1:0]  c_data;
  logic               wr_ready;
  logic               wr_ready2;
  logic               wr_en, busy, done, overrun;
  logic [AW-1:0]      wr_addr;
  logic [ROW_W-1:0]   wr_data;
  logic               wr_en2, busy2, done2, overrun2;
  logic [AW-1:0]      wr_addr2;
  logic [ROW_W-1:0]   wr_data2;

  logic signed [AC-1:0] elems [N*N];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycles;

  always #5 clk = ~clk;

  matmul_result_writer #(.N(N), .ACC_W(AC), .DW(8), .SHIFT(0), .ADDR_W(AW), .ROW_STRIDE(1)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_done_mat_mul(done_mm), .i_clear_done(clear_done),
    .i_base_addr(base), .i_c_data(c_data), .i_wr_ready(wr_ready),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_overrun(overrun));

  matmul_result_writer #(.N(N), .ACC_W(AC), .DW(8), .SHIFT(2), .ADDR_W(AW), .ROW_STRIDE(1)) dut_s2 (
    .i_clk(clk), .i_resetn(resetn), .i_done_mat_mul(done_mm), .i_clear_done(clear_done),
    .i_base_addr(base), .i_c_data(c_data), .i_wr_ready(wr_ready2),
    .o_wr_en(wr_en2), .o_wr_addr(wr_addr2), .o_wr_data(wr_data2),
    .o_busy(busy2), .o_done(done2), .o_overrun(overrun2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] requant(input logic signed [AC-1:0] acc, input int sh);
    logic signed [AC-1:0] s;
    s = acc >>> sh;
    if (s > 127)       return 8'h7F;
    else if (s < -128) return 8'h80;
    else               return s[7:0];
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input int r, input int sh);
    logic [ROW_W-1:0] d;
    d = '0;
    for (int c = 0; c < N; c++) d[c*8 +: 8] = requant(elems[r*N+c], sh);
    return d;
  endfunction

  // Drive a one-cycle done_mat_mul pulse and queue the rows it should produce.
  task automatic capture(input logic [AW-1:0] b, input logic rdy, input logic clr);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < N*N; i++) c_data[i*AC +: AC] = elems[i];
    base       = b;
    done_mm    = 1'b1;
    clear_done = clr;
    wr_ready   = rdy;
    for (int r = 0; r < N; r++) begin
      e.addr = b + AW'(r);
      e.data = exp_row(r, 0);
      sb.push_back(e);
    end
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input int ovr_at, input int stop_after, input int budget);
    int popped;
    exp_t e;
    popped = 0;
    cycles = 0;
    while (sb.size() > 0 && cycles < budget && popped < stop_after) begin
      @(negedge clk);
      done_mm    = 1'b0;
      clear_done = 1'b0;
      wr_ready   = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      if (cycles == ovr_at) begin
        done_mm = 1'b1;
        c_data  = ~c_data;
      end
      cycles++;
      chk("busy_during_write", busy, 1'b1);
      chk("done_during_write", done, 1'b0);
      chk("wr_en_during_write", wr_en, 1'b1);
      e = sb[0];
      chk("wr_addr", wr_addr, e.addr);
      chk("wr_data", wr_data, e.data);
      if (wr_ready) begin
        void'(sb.pop_front());
        popped++;
      end
    end
    if (stop_after >= N) chk("all_rows_written", sb.size(), 0);
  endtask

  task automatic check_done_state(input string tag);
    @(negedge clk);
    done_mm    = 1'b0;
    clear_done = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; done_mm = 1'b0; clear_done = 1'b0; base = '0;
    c_data = '0; wr_ready = 1'b1; wr_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    resetn = 1'b1;
    @(negedge clk);

    // All-ones 8x8 product: every element is 8.
    for (int i = 0; i < N*N; i++) elems[i] = 16'sd8;
    capture(7'h10, 1'b1, 1'b0);
    drain(0, -1, N, 40);
    chk("ones_cycles", cycles, N);
    chk("ones_row_value", exp_row(3, 0), 64'h0808080808080808);
    check_done_state("ones");

    // Saturation corners; main DUT stalled one cycle so the SHIFT=2 copy
    // can be inspected on its first row.
    for (int i = 0; i < N*N; i++) begin
      case (i % 4)
        0: elems[i] = 16'sh7FFF;
        1: elems[i] = 16'sh8000;
        2: elems[i] = 16'sh0042;
        default: elems[i] = 16'shFED4;
      endcase
    end
    elems[4] = 16'sh0101;
    capture(7'h20, 1'b0, 1'b0);
    @(negedge clk);
    done_mm = 1'b0;
    chk("sat_row0_low32", wr_data[31:0], 32'h8042807F);
    chk("s2_wr_en", wr_en2, 1'b1);
    chk("s2_0101", wr_data2[39:32], 8'h40);
    chk("s2_row0", wr_data2, exp_row(0, 2));
    drain(0, -1, N, 40);
    check_done_state("sat");

    // Backpressure with random data.
    for (int i = 0; i < N*N; i++) elems[i] = AC'($urandom);
    capture(7'h05, 1'b1, 1'b0);
    drain(1, -1, N, 60);
    check_done_state("bp");

    // Address wrap past 7F.
    for (int i = 0; i < N*N; i++) elems[i] = AC'($urandom_range(0, 255)) - 16'sd128;
    capture(7'h7E, 1'b1, 1'b0);
    drain(0, -1, N, 40);
    check_done_state("wrap");

    // Second rise while writing: ignored, sticky overrun.
    for (int i = 0; i < N*N; i++) elems[i] = AC'($urandom);
    capture(7'h30, 1'b1, 1'b0);
    drain(0, 3, N, 40);
    check_done_state("ovr");
    chk("overrun_set", overrun, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_held", done, 1'b1);
    clear_done = 1'b1;
    @(negedge clk);
    clear_done = 1'b0;
    chk("clear_done", done, 1'b0);
    chk("clear_busy", busy, 1'b0);

    // clear_done coincident with a new rise: capture wins.
    capture(7'h40, 1'b1, 1'b0);
    drain(0, -1, N, 40);
    check_done_state("pre_coinc");
    for (int i = 0; i < N*N; i++) elems[i] = AC'($urandom);
    capture(7'h48, 1'b1, 1'b1);
    drain(0, -1, N, 40);
    check_done_state("coinc");
    chk("overrun_sticky", overrun, 1'b1);

    // Reset during WRITE after three accepted rows.
    for (int i = 0; i < N*N; i++) elems[i] = AC'($urandom);
    capture(7'h50, 1'b1, 1'b0);
    drain(0, -1, 3, 40);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_wr_en", wr_en, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_overrun", overrun, 1'b0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    capture(7'h50, 1'b1, 1'b0);
    drain(0, -1, N, 40);
    check_done_state("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
